// File: rtl/rvfi_check_sched.sv
// Schedules a single formal-style check on one RVFI retirement channel.
// Arms after a minimum cycle count and fires the check strobe when the
// target instruction (by rvfi_order) retires on the chosen channel. It
// records a miss if that instruction is seen out of place or is overtaken,
// and times out if nothing happens before the cycle limit.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for enable and cycle_cnt >= MIN_CYCLE
// ARMED   | watching retirements for trigger_order
// DONE    | check strobe fired (terminal until reset)
// MISSED  | trigger overtaken or retired on another channel (terminal)
// TIMEOUT | cycle_cnt reached MAX_CYCLE without firing (terminal)
module rvfi_check_sched #(
  parameter int unsigned NRET        = 1,
  parameter int unsigned CHANNEL_IDX = 0,
  parameter int unsigned MIN_CYCLE   = 4,
  parameter int unsigned MAX_CYCLE   = 20
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [63:0]          trigger_order,
  input  logic [NRET-1:0]      rvfi_valid,
  input  logic [64*NRET-1:0]   rvfi_order,
  output logic                 check,
  output logic                 armed,
  output logic                 done,
  output logic                 missed,
  output logic                 timeout,
  output logic [15:0]          cycle_cnt,
  output logic [7:0]           retired_cnt
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    DONE    = 3'd2,
    MISSED  = 3'd3,
    TIMEOUT = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] cycle_q, cycle_d;
  logic [7:0]  retired_q, retired_d;
  logic        armed_q, done_q, missed_q, timeout_q;
  logic        check_w;
  logic        miss_w;
  logic [15:0] pop_w;
  logic [15:0] ret_sum_w;

  // Trigger match on the target channel and the out-of-order/overtaken detect.
  always_comb begin
    check_w = 1'b0;
    miss_w  = 1'b0;
    pop_w   = 16'd0;
    if (!reset && state_q == ARMED && rvfi_valid[CHANNEL_IDX] &&
        rvfi_order[64*CHANNEL_IDX +: 64] == trigger_order) begin
      check_w = 1'b1;
    end
    for (int unsigned i = 0; i < NRET; i++) begin
      pop_w = pop_w + 16'(rvfi_valid[i]);
      if (rvfi_valid[i]) begin
        if (rvfi_order[64*i +: 64] > trigger_order) begin
          miss_w = 1'b1;
        end
        if (i != CHANNEL_IDX && rvfi_order[64*i +: 64] == trigger_order) begin
          miss_w = 1'b1;
        end
      end
    end
  end

  // Next-state, saturating counters; DONE beats MISSED beats TIMEOUT.
  always_comb begin
    state_d   = state_q;
    cycle_d   = (cycle_q == 16'hFFFF) ? cycle_q : cycle_q + 16'd1;
    retired_d = retired_q;
    ret_sum_w = {8'd0, retired_q} + pop_w;
    unique case (state_q)
      IDLE: begin
        if (cycle_q == 16'(MAX_CYCLE)) begin
          state_d = TIMEOUT;
        end else if (enable && cycle_q >= 16'(MIN_CYCLE)) begin
          state_d = ARMED;
        end
      end
      ARMED: begin
        retired_d = (ret_sum_w > 16'h00FF) ? 8'hFF : ret_sum_w[7:0];
        if (check_w) begin
          state_d = DONE;
        end else if (miss_w) begin
          state_d = MISSED;
        end else if (cycle_q == 16'(MAX_CYCLE)) begin
          state_d = TIMEOUT;
        end
      end
      DONE, MISSED, TIMEOUT: state_d = state_q;
      default: state_d = IDLE;
    endcase
  end

  // State, counters and status flags; flags follow the next state so they
  // line up exactly with the state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      cycle_q   <= 16'd0;
      retired_q <= 8'd0;
      armed_q   <= 1'b0;
      done_q    <= 1'b0;
      missed_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cycle_q   <= cycle_d;
      retired_q <= retired_d;
      armed_q   <= (state_d == ARMED);
      done_q    <= (state_d == DONE);
      missed_q  <= (state_d == MISSED);
      timeout_q <= (state_d == TIMEOUT);
    end
  end

  assign check       = check_w;
  assign armed       = armed_q;
  assign done        = done_q;
  assign missed      = missed_q;
  assign timeout     = timeout_q;
  assign cycle_cnt   = cycle_q;
  assign retired_cnt = retired_q;

endmodule

// File: tb/tb_rvfi_check_sched.sv
// Directed bench for rvfi_check_sched with two channels, target channel 1,
// trigger order 10. "Cycle n" is the cycle in which cycle_cnt reads n.
module tb_rvfi_check_sched;

  logic          clock = 1'b0;
  logic          reset;
  logic          enable;
  logic [63:0]   trigger_order;
  logic [1:0]    rvfi_valid;
  logic [127:0]  rvfi_order;
  logic          check, armed, done, missed, timeout;
  logic [15:0]   cycle_cnt;
  logic [7:0]    retired_cnt;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  rvfi_check_sched #(
    .NRET(2), .CHANNEL_IDX(1), .MIN_CYCLE(4), .MAX_CYCLE(20)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .trigger_order(trigger_order), .rvfi_valid(rvfi_valid),
    .rvfi_order(rvfi_order), .check(check), .armed(armed), .done(done),
    .missed(missed), .timeout(timeout), .cycle_cnt(cycle_cnt),
    .retired_cnt(retired_cnt)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic go_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic set_ret(input logic [1:0] v, input logic [63:0] o0, input logic [63:0] o1);
    rvfi_valid = v;
    rvfi_order = {o1, o0};
    #1;
  endtask

  task automatic do_reset(input logic en);
    reset = 1'b1;
    enable = en;
    trigger_order = 64'd10;
    rvfi_valid = 2'b00;
    rvfi_order = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    enable = 1'b1;
    trigger_order = 64'd10;
    rvfi_valid = 2'b10;
    rvfi_order = {64'd10, 64'd0};
    repeat (3) @(posedge clock);
    #1;
    total++;
    if ({check, armed, done, missed, timeout} !== 5'b0) $display("FAIL reset_flags got=%b want=00000", {check, armed, done, missed, timeout});
    else passed++;
    total++;
    if (cycle_cnt !== 16'd0 || retired_cnt !== 8'd0) $display("FAIL reset_counts got cyc=%0d ret=%0d want 0/0", cycle_cnt, retired_cnt);
    else passed++;
    rvfi_valid = 2'b00;
    rvfi_order = '0;
    #1;
    reset = 1'b0;
    cyc = 0;
    go_to(3);
    total++;
    if (cycle_cnt !== 16'd3) $display("FAIL cycle_count got=%0d want=3", cycle_cnt);
    else passed++;
  endtask

  task automatic test_done();
    do_reset(1'b1);
    go_to(4);
    total++;
    if (armed !== 1'b0 || cycle_cnt !== 16'd4) $display("FAIL arm_c4 got armed=%b cyc=%0d want 0/4", armed, cycle_cnt);
    else passed++;
    go_to(5);
    total++;
    if (armed !== 1'b1 || check !== 1'b0) $display("FAIL arm_c5 got armed=%b check=%b want 1/0", armed, check);
    else passed++;
    go_to(6);
    set_ret(2'b10, 64'd0, 64'd10);
    total++;
    if (check !== 1'b1) $display("FAIL done_check got=%b want=1", check);
    else passed++;
    tick();
    set_ret(2'b10, 64'd0, 64'd10);
    total++;
    if (done !== 1'b1 || armed !== 1'b0 || check !== 1'b0) $display("FAIL done_c7 got done=%b armed=%b check=%b want 1/0/0", done, armed, check);
    else passed++;
    total++;
    if (retired_cnt !== 8'd1) $display("FAIL done_retired got=%0d want=1", retired_cnt);
    else passed++;
    set_ret(2'b00, 64'd0, 64'd0);
  endtask

  task automatic test_missed();
    do_reset(1'b1);
    go_to(5);
    set_ret(2'b01, 64'd11, 64'd0);
    total++;
    if (check !== 1'b0) $display("FAIL missed_check_c5 got=%b want=0", check);
    else passed++;
    tick();
    set_ret(2'b10, 64'd0, 64'd10);
    total++;
    if (missed !== 1'b1 || armed !== 1'b0 || check !== 1'b0) $display("FAIL missed_c6 got missed=%b armed=%b check=%b want 1/0/0", missed, armed, check);
    else passed++;
    set_ret(2'b00, 64'd0, 64'd0);
  endtask

  task automatic test_same_cycle();
    do_reset(1'b1);
    go_to(6);
    set_ret(2'b11, 64'd11, 64'd10);
    total++;
    if (check !== 1'b1) $display("FAIL same_check got=%b want=1", check);
    else passed++;
    tick();
    set_ret(2'b00, 64'd0, 64'd0);
    total++;
    if (done !== 1'b1 || missed !== 1'b0) $display("FAIL same_next got done=%b missed=%b want 1/0", done, missed);
    else passed++;
    total++;
    if (retired_cnt !== 8'd2) $display("FAIL same_retired got=%0d want=2", retired_cnt);
    else passed++;
  endtask

  task automatic test_other_channel_equal();
    do_reset(1'b1);
    go_to(7);
    set_ret(2'b01, 64'd10, 64'd0);
    total++;
    if (check !== 1'b0) $display("FAIL ch0_eq_check got=%b want=0", check);
    else passed++;
    tick();
    set_ret(2'b00, 64'd0, 64'd0);
    total++;
    if (missed !== 1'b1) $display("FAIL ch0_eq_missed got=%b want=1", missed);
    else passed++;
  endtask

  task automatic test_timeout_idle();
    do_reset(1'b0);
    go_to(10);
    set_ret(2'b10, 64'd0, 64'd10);
    total++;
    if (check !== 1'b0) $display("FAIL idle_check got=%b want=0", check);
    else passed++;
    set_ret(2'b00, 64'd0, 64'd0);
    go_to(20);
    total++;
    if (timeout !== 1'b0 || cycle_cnt !== 16'd20) $display("FAIL to_c20 got to=%b cyc=%0d want 0/20", timeout, cycle_cnt);
    else passed++;
    tick();
    total++;
    if (timeout !== 1'b1 || armed !== 1'b0) $display("FAIL to_c21 got to=%b armed=%b want 1/0", timeout, armed);
    else passed++;
  endtask

  task automatic test_timeout_armed();
    do_reset(1'b1);
    go_to(5);
    set_ret(2'b11, 64'd5, 64'd5);
    go_to(20);
    total++;
    if (armed !== 1'b1 || timeout !== 1'b0) $display("FAIL toa_c20 got armed=%b to=%b want 1/0", armed, timeout);
    else passed++;
    tick();
    set_ret(2'b00, 64'd0, 64'd0);
    total++;
    if (timeout !== 1'b1 || retired_cnt !== 8'd32) $display("FAIL toa_c21 got to=%b ret=%0d want 1/32", timeout, retired_cnt);
    else passed++;
  endtask

  task automatic test_reset_mid_armed();
    do_reset(1'b1);
    go_to(5);
    total++;
    if (armed !== 1'b1) $display("FAIL rst_pre got armed=%b want=1", armed);
    else passed++;
    reset = 1'b1;
    set_ret(2'b10, 64'd0, 64'd10);
    total++;
    if (check !== 1'b0) $display("FAIL rst_check got=%b want=0", check);
    else passed++;
    tick();
    total++;
    if ({armed, done, missed, timeout} !== 4'b0 || cycle_cnt !== 16'd0 || retired_cnt !== 8'd0) $display("FAIL rst_clear got flags=%b cyc=%0d ret=%0d want 0000/0/0", {armed, done, missed, timeout}, cycle_cnt, retired_cnt);
    else passed++;
    set_ret(2'b00, 64'd0, 64'd0);
    reset = 1'b0;
    cyc = 0;
    go_to(4);
    total++;
    if (armed !== 1'b0 || cycle_cnt !== 16'd4) $display("FAIL rearm_c4 got armed=%b cyc=%0d want 0/4", armed, cycle_cnt);
    else passed++;
    tick();
    total++;
    if (armed !== 1'b1) $display("FAIL rearm_c5 got armed=%b want=1", armed);
    else passed++;
  endtask

  task automatic test_pre_arm_trigger();
    do_reset(1'b1);
    go_to(2);
    set_ret(2'b10, 64'd0, 64'd10);
    total++;
    if (check !== 1'b0) $display("FAIL prearm_check got=%b want=0", check);
    else passed++;
    tick();
    set_ret(2'b00, 64'd0, 64'd0);
    go_to(5);
    set_ret(2'b01, 64'd11, 64'd0);
    tick();
    set_ret(2'b00, 64'd0, 64'd0);
    total++;
    if (missed !== 1'b1 || retired_cnt !== 8'd1) $display("FAIL prearm_missed got missed=%b ret=%0d want 1/1", missed, retired_cnt);
    else passed++;
  endtask

  initial begin
    reset = 1'b1;
    enable = 1'b0;
    trigger_order = 64'd10;
    rvfi_valid = 2'b00;
    rvfi_order = '0;
    test_reset();
    test_done();
    test_missed();
    test_same_cycle();
    test_other_channel_equal();
    test_timeout_idle();
    test_timeout_armed();
    test_reset_mid_armed();
    test_pre_arm_trigger();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
